// File: rtl/fifo_prog_thresh.sv
// fifo_prog_thresh: synchronous FIFO with live programmable almost-full/empty thresholds and sticky error flags.
// Define FIFO_HWM_EN to enable high-water-mark tracking on o_max_count; otherwise it is tied to 0.
module fifo_prog_thresh #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_write_en,
   input  logic                  i_read_en,
   input  logic [DATA_WIDTH-1:0] i_data_in,
   input  logic [ADDR_WIDTH:0]   i_af_thresh,
   input  logic [ADDR_WIDTH:0]   i_ae_thresh,
   input  logic                  i_err_clr,
   output logic [DATA_WIDTH-1:0] o_data_out,
   output logic                  o_data_valid,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_almost_full,
   output logic                  o_almost_empty,
   output logic                  o_overflow,
   output logic                  o_underflow,
   output logic                  o_overflow_sticky,
   output logic                  o_underflow_sticky,
   output logic [ADDR_WIDTH:0]   o_max_count
);
   localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DEPTH-1);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_data_valid, r_overflow, r_underflow, r_ovf_sticky, r_udf_sticky;
   logic                  w_full, w_empty, w_read_acc, w_write_acc, w_overflow, w_underflow;
   logic [ADDR_WIDTH:0]   w_count_nxt;
   always_comb begin
      w_full      = r_count == DEPTH_C;
      w_empty     = r_count == '0;
      w_read_acc  = i_read_en && !w_empty;
      w_write_acc = i_write_en && (!w_full || i_read_en);
      w_overflow  = i_write_en && !w_write_acc;
      w_underflow = i_read_en && w_empty;
      w_count_nxt = r_count + (ADDR_WIDTH+1)'(w_write_acc) - (ADDR_WIDTH+1)'(w_read_acc);
   end
   always_ff @(posedge i_clk)
      if (!i_reset && w_write_acc) r_mem[r_wr_ptr] <= i_data_in;
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_overflow   <= 1'b0;
         r_underflow  <= 1'b0;
         r_ovf_sticky <= 1'b0;
         r_udf_sticky <= 1'b0;
      end else begin
         if (w_write_acc) r_wr_ptr <= (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + 1'b1;
         if (w_read_acc) begin
            r_rd_ptr   <= (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + 1'b1;
            r_data_out <= r_mem[r_rd_ptr];
         end
         r_data_valid <= w_read_acc;
         r_count      <= w_count_nxt;
         r_overflow   <= w_overflow;
         r_underflow  <= w_underflow;
         // a new error in the clearing cycle must stay visible
         r_ovf_sticky <= w_overflow || (r_ovf_sticky && !i_err_clr);
         r_udf_sticky <= w_underflow || (r_udf_sticky && !i_err_clr);
      end
   end
`ifdef FIFO_HWM_EN
   logic [ADDR_WIDTH:0] r_max_count;
   always_ff @(posedge i_clk) begin
      if (i_reset) r_max_count <= '0;
      else if (w_count_nxt > r_max_count) r_max_count <= w_count_nxt;
      else if (i_err_clr) r_max_count <= '0;
   end
   assign o_max_count = r_max_count;
`else
   assign o_max_count = '0;
`endif
   assign o_data_out         = r_data_out;
   assign o_data_valid       = r_data_valid;
   assign o_count            = r_count;
   assign o_full             = w_full;
   assign o_empty            = w_empty;
   assign o_almost_full      = r_count >= i_af_thresh;
   assign o_almost_empty     = r_count <= i_ae_thresh;
   assign o_overflow         = r_overflow;
   assign o_underflow        = r_underflow;
   assign o_overflow_sticky  = r_ovf_sticky;
   assign o_underflow_sticky = r_udf_sticky;
endmodule

// File: tb/tb_fifo_prog_thresh.sv
// tb_fifo_prog_thresh: directed vector table, corner sequences and randomized traffic against a queue model.
module tb_fifo_prog_thresh;
   localparam int DW = 16, D = 8, AW = 3;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic          rst = 1'b1, we = 1'b0, re = 1'b0, clr = 1'b0;
   logic [DW-1:0] din = '0;
   logic [AW:0]   af = 4'd6, ae = 4'd2;
   logic [DW-1:0] dout;
   logic          dv, full, empty, afl, ael, ovf, udf, os, us;
   logic [AW:0]   cnt, mx;
   fifo_prog_thresh #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
      .i_clk(clk), .i_reset(rst), .i_write_en(we), .i_read_en(re), .i_data_in(din),
      .i_af_thresh(af), .i_ae_thresh(ae), .i_err_clr(clr),
      .o_data_out(dout), .o_data_valid(dv), .o_count(cnt), .o_full(full), .o_empty(empty),
      .o_almost_full(afl), .o_almost_empty(ael), .o_overflow(ovf), .o_underflow(udf),
      .o_overflow_sticky(os), .o_underflow_sticky(us), .o_max_count(mx));
   int n_chk = 0, n_pass = 0;
   logic [DW-1:0] q[$];
   int m_dout = 0, m_dv = 0, m_ovf = 0, m_udf = 0, m_os = 0, m_us = 0, m_max = 0;
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask
   task automatic model_edge();
      int n = q.size();
      bit rd, wr;
      if (rst) begin
         q.delete();
         {m_dout, m_dv, m_ovf, m_udf, m_os, m_us, m_max} = '0;
      end else begin
         rd = re && n > 0;
         wr = we && (n < D || re);
         m_dv = rd;
         if (rd) m_dout = int'(q.pop_front());
         if (wr) q.push_back(din);
         m_ovf = we && !wr;
         m_udf = re && n == 0;
         m_os = m_ovf || (m_os && !clr);
         m_us = m_udf || (m_us && !clr);
         if (q.size() > m_max) m_max = q.size();
         else if (clr) m_max = 0;
      end
   endtask
   task automatic cmp_model();
      int n = q.size();
      chk("count", int'(cnt), n);
      chk("full", int'(full), int'(n == D));
      chk("empty", int'(empty), int'(n == 0));
      chk("almost_full", int'(afl), int'(n >= int'(af)));
      chk("almost_empty", int'(ael), int'(n <= int'(ae)));
      chk("data_valid", int'(dv), m_dv);
      chk("data_out", int'(dout), m_dout);
      chk("overflow", int'(ovf), m_ovf);
      chk("underflow", int'(udf), m_udf);
      chk("overflow_sticky", int'(os), m_os);
      chk("underflow_sticky", int'(us), m_us);
`ifdef FIFO_HWM_EN
      chk("max_count", int'(mx), m_max);
`else
      chk("max_count", int'(mx), 0);
`endif
   endtask
   task automatic cyc(input int r, input int w, input int rd, input int c, input int d);
      rst = 1'(r); we = 1'(w); re = 1'(rd); clr = 1'(c); din = DW'(d);
      @(posedge clk);
      model_edge();
      #1;
      cmp_model();
   endtask
   typedef struct {
      int rst, we, re, clr, din;
      int cnt, dout, dv, full, empty, ae, af, ovf, udf, os, us;
   } vec_t;
   vec_t tbl[17];
   initial begin
      tbl[0]  = '{1,0,0,0,0,   0,0,0,0,1,1,0,0,0,0,0};
      tbl[1]  = '{0,0,1,0,0,   0,0,0,0,1,1,0,0,1,0,1};
      tbl[2]  = '{0,0,0,1,0,   0,0,0,0,1,1,0,0,0,0,0};
      tbl[3]  = '{0,1,0,0,1,   1,0,0,0,0,1,0,0,0,0,0};
      tbl[4]  = '{0,1,0,0,2,   2,0,0,0,0,1,0,0,0,0,0};
      tbl[5]  = '{0,1,0,0,3,   3,0,0,0,0,0,0,0,0,0,0};
      tbl[6]  = '{0,1,0,0,4,   4,0,0,0,0,0,0,0,0,0,0};
      tbl[7]  = '{0,1,0,0,5,   5,0,0,0,0,0,0,0,0,0,0};
      tbl[8]  = '{0,1,0,0,6,   6,0,0,0,0,0,1,0,0,0,0};
      tbl[9]  = '{0,1,0,0,7,   7,0,0,0,0,0,1,0,0,0,0};
      tbl[10] = '{0,1,0,0,8,   8,0,0,1,0,0,1,0,0,0,0};
      tbl[11] = '{0,1,0,0,9,   8,0,0,1,0,0,1,1,0,1,0};
      tbl[12] = '{0,1,1,0,10,  8,1,1,1,0,0,1,0,0,1,0};
      tbl[13] = '{0,0,1,0,0,   7,2,1,0,0,0,1,0,0,1,0};
      tbl[14] = '{0,0,0,0,0,   7,2,0,0,0,0,1,0,0,1,0};
      tbl[15] = '{0,0,0,1,0,   7,2,0,0,0,0,1,0,0,0,0};
      tbl[16] = '{1,0,0,0,0,   0,0,0,0,1,1,0,0,0,0,0};
      for (int i = 0; i < 17; i++) begin
         cyc(tbl[i].rst, tbl[i].we, tbl[i].re, tbl[i].clr, tbl[i].din);
         chk($sformatf("v%0d_count", i), int'(cnt), tbl[i].cnt);
         chk($sformatf("v%0d_dout", i), int'(dout), tbl[i].dout);
         chk($sformatf("v%0d_dv", i), int'(dv), tbl[i].dv);
         chk($sformatf("v%0d_full", i), int'(full), tbl[i].full);
         chk($sformatf("v%0d_empty", i), int'(empty), tbl[i].empty);
         chk($sformatf("v%0d_ae", i), int'(ael), tbl[i].ae);
         chk($sformatf("v%0d_af", i), int'(afl), tbl[i].af);
         chk($sformatf("v%0d_ovf", i), int'(ovf), tbl[i].ovf);
         chk($sformatf("v%0d_udf", i), int'(udf), tbl[i].udf);
         chk($sformatf("v%0d_os", i), int'(os), tbl[i].os);
         chk($sformatf("v%0d_us", i), int'(us), tbl[i].us);
      end
      // full FIFO with simultaneous read/write across pointer wrap
      for (int i = 1; i <= 8; i++) cyc(0, 1, 0, 0, i);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 1, 0, 'h11 + i);
         chk("wrap_dout", int'(dout), i + 1);
         chk("wrap_count", int'(cnt), 8);
         chk("wrap_ovf", int'(ovf), 0);
         chk("wrap_full", int'(full), 1);
      end
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 1, 0, 0);
         chk("drain_dout", int'(dout), i < 4 ? 5 + i : 'h11 + i - 4);
      end
      chk("drain_empty", int'(empty), 1);
      // simultaneous read/write when empty
      cyc(0, 1, 1, 0, 'h55);
      chk("empty_rw_count", int'(cnt), 1);
      chk("empty_rw_udf", int'(udf), 1);
      chk("empty_rw_dv", int'(dv), 0);
      // high-water mark: fill to 5, drain to 1
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, i);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
      chk("hwm_count", int'(cnt), 1);
`ifdef FIFO_HWM_EN
      chk("hwm_max", int'(mx), 5);
`else
      chk("hwm_max", int'(mx), 0);
`endif
      // thresholds are live: change without a clock edge
      af = 4'd1; ae = 4'd0; #1;
      chk("live_af1", int'(afl), 1);
      chk("live_ae0", int'(ael), 0);
      af = 4'd2; ae = 4'd1; #1;
      chk("live_af2", int'(afl), 0);
      chk("live_ae1", int'(ael), 1);
      // reset mid-fill with a pending write
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, i);
      cyc(1, 1, 0, 0, 'h77);
      chk("rst_mid_count", int'(cnt), 0);
      chk("rst_mid_max", int'(mx), 0);
      chk("rst_mid_empty", int'(empty), 1);
      for (int i = 0; i < 3000; i++) begin
         int wb = (i / 200) % 3;
         af = (AW+1)'($urandom_range(0, 9));
         ae = (AW+1)'($urandom_range(0, 9));
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) < wb + 1, $urandom_range(0, 3) < 3 - wb,
             $urandom_range(0, 15) == 0, int'($urandom_range(0, 65535)));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/fifo_prog_thresh.md
FIFO_PROG_THRESH -- requirements
Module: fifo_prog_thresh

Interface
REQ-001: Parameter DATA_WIDTH, default 16, width of each data word.
REQ-002: Parameter DEPTH, default 8, number of storage entries; any value >= 2, power of two not required.
REQ-003: Parameter ADDR_WIDTH, default 3, pointer width; SHALL satisfy 2**ADDR_WIDTH >= DEPTH.
REQ-004: clk  input  1  single clock; all state updates on its rising edge.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: write_en  input  1  write request.
REQ-007: read_en  input  1  read request.
REQ-008: data_in  input  DATA_WIDTH  write data.
REQ-009: af_thresh  input  ADDR_WIDTH+1  almost-full threshold.
REQ-010: ae_thresh  input  ADDR_WIDTH+1  almost-empty threshold.
REQ-011: err_clr  input  1  clears sticky error flags and the high-water mark.
REQ-012: data_out  output  DATA_WIDTH  registered read data.
REQ-013: data_valid  output  1  one-cycle pulse marking new data_out.
REQ-014: count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-015: full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-016: overflow, underflow  output  1 each  one-cycle pulses for rejected requests.
REQ-017: overflow_sticky, underflow_sticky  output  1 each  latched error flags.
REQ-018: max_count  output  ADDR_WIDTH+1  high-water mark.

Function
REQ-019: read_acc = read_en && !empty; write_acc = write_en && (!full || read_en).
REQ-020: On write_acc, data_in SHALL be written at wr_ptr; wr_ptr SHALL advance, wrapping from DEPTH-1 to 0.
REQ-021: On read_acc, data_out SHALL load mem[rd_ptr] at that edge (1-cycle latency); rd_ptr SHALL advance with the same wrap; data_valid SHALL be 1 for that cycle only.
REQ-022: Without read_acc, data_out SHALL hold its value and data_valid SHALL be 0.
REQ-023: count SHALL update as count + write_acc - read_acc; it SHALL never exceed DEPTH or go below 0.
REQ-024: full = (count == DEPTH); empty = (count == 0); both decoded from registered count.
REQ-025: almost_full = (count >= af_thresh); almost_empty = (count <= ae_thresh); thresholds are used live, not latched.
REQ-026: Simultaneous read and write when full: both accepted, count unchanged, full stays 1, no overflow.
REQ-027: Simultaneous read and write when empty: write accepted, read rejected, underflow pulses, count becomes 1.
REQ-028: overflow SHALL pulse 1 cycle when write_en && !write_acc; underflow SHALL pulse 1 cycle when read_en && empty.
REQ-029: Sticky flags SHALL set on the corresponding pulse and clear on err_clr; set SHALL win if both occur in the same cycle.
REQ-030: Rejected requests SHALL change no pointer, count or memory entry.

Reset
REQ-031: While reset is 1 at a rising clk edge: pointers, count, data_out, data_valid, overflow, underflow, both sticky flags and max_count SHALL be 0.
REQ-032: After reset: empty=1, full=0; almost_empty and almost_full follow REQ-025 with count=0.
REQ-033: Memory contents SHALL NOT be reset; requests in the reset cycle SHALL be discarded.

Configuration
REQ-034: Macro FIFO_HWM_EN defined: max_count SHALL take the next count value whenever that value exceeds max_count; err_clr SHALL set it to 0, with update winning in the same cycle.
REQ-035: Macro FIFO_HWM_EN undefined: the max_count port SHALL remain present and be driven constant 0, with no tracking logic.

Verification (DATA_WIDTH=16, DEPTH=8)
REQ-036: Write 0x0001..0x0008, then 8 reads -> data_out 0x0001..0x0008 in order, each one cycle after read_en; full after 8th write; empty after 8th read.
REQ-037: Read on empty after reset -> underflow pulse, underflow_sticky=1, count=0; err_clr -> sticky clears.
REQ-038: 9 writes with no read -> 9th raises overflow; mem and count=8 unchanged; overflow_sticky=1.
REQ-039: When full, write_en and read_en together for 4 cycles -> count stays 8, no overflow, FIFO data order preserved across pointer wrap.
REQ-040: af_thresh=6, ae_thresh=2; fill 0 to 8 -> almost_empty=1 for count<=2, almost_full=1 for count>=6.
REQ-041: With FIFO_HWM_EN, fill to 5 and drain to 1 -> max_count=5; reset asserted mid-fill at count=3 -> count=0 and max_count=0 on the next edge.
